lsu_mem_ctrl: RTL and testbench

- Load/store unit between the core's data-side outputs and a word-wide, handshaked data SRAM.
- Core side: effective address (ALU result), store data, op class and funct3 per access.
- Memory side: byte strobes, replicated store data, one outstanding request.
- Sign/zero-extends load data; stalls the core for multi-cycle or slow memory; flags misaligned, illegal and timed-out accesses.

---
 rtl/mem_pkg.sv | 60 ++++++
 rtl/lsu_load_align.sv | 34 +++
 rtl/lsu_mem_ctrl.sv | 140 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the load/store unit: RV32I funct3 codes,
// FSM state type and store-lane / access-legality functions.
package mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} lsu_state_t;

  // True when the access is misaligned for its size or uses an unused funct3.
  function automatic logic access_bad(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] off);
    logic bad;
    if (we) begin
      case (funct3)
        SB:      bad = 1'b0;
        SH:      bad = off[0];
        SW:      bad = |off;
        default: bad = 1'b1;
      endcase
    end else begin
      case (funct3)
        LB, LBU: bad = 1'b0;
        LH, LHU: bad = off[0];
        LW:      bad = |off;
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] strb;
    case (funct3)
      SB:      strb = 4'b0001 << off;
      SH:      strb = 4'b0011 << off;
      SW:      strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] data;
    case (funct3)
      SB:      data = {4{wdata[7:0]}};
      SH:      data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a memory word and sign/zero-extends it
// according to the RV32I load funct3.
module lsu_load_align
  import mem_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (funct3)
      LB:      ext_data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     ext_data = {24'h000000, byte_sel};
      LH:      ext_data = {{16{half_sel[15]}}, half_sel};
      LHU:     ext_data = {16'h0000, half_sel};
      default: ext_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns one core access into a single handshaked SRAM request,
// stalling the core until completion and flagging misaligned/illegal/timed-out accesses.
module lsu_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [2:0]    funct3,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          stall,
  output logic          done,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wstrb,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_t  state_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] load_word;
  logic        timeout;

  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  lsu_load_align u_load_align (
    .mem_rdata (mem_rdata),
    .offset    (off_q),
    .funct3    (funct3_q),
    .ext_data  (load_word)
  );

  // cnt_q counts cycles already spent in ISSUE/WAIT; this is the TIMEOUT-th one.
  assign timeout = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // Gated by reset so an abandoned access releases the core immediately.
  assign stall = !reset && (((state_q == IDLE) && req) || (state_q == ISSUE) ||
                            (state_q == WAIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      funct3_q  <= 3'b000;
      off_q     <= 2'b00;
      cnt_q     <= '0;
      rdata     <= 32'h0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            funct3_q  <= funct3;
            off_q     <= addr[1:0];
            mem_we    <= we;
            mem_addr  <= addr[AW+1:2];
            mem_wstrb <= we ? store_strb(funct3, addr[1:0]) : 4'b0000;
            mem_wdata <= store_data(funct3, wdata);
            cnt_q     <= '0;
            if (access_bad(we, funct3, addr[1:0])) begin
              state_q <= DONE;
              done    <= 1'b1;
              err     <= 1'b1;
              rdata   <= 32'h0;
            end else begin
              state_q <= ISSUE;
              mem_req <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + 1'b1;
          if (timeout) begin
            state_q <= DONE;
            mem_req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            rdata   <= 32'h0;
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state_q <= DONE;
              done    <= 1'b1;
              err     <= 1'b0;
            end else if (mem_rvalid) begin
              state_q <= DONE;
              done    <= 1'b1;
              err     <= 1'b0;
              rdata   <= load_word;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (timeout) begin
            state_q <= DONE;
            done    <= 1'b1;
            err     <= 1'b1;
            rdata   <= 32'h0;
          end else if (mem_rvalid) begin
            state_q <= DONE;
            done    <= 1'b1;
            err     <= 1'b0;
            rdata   <= load_word;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
          err     <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a scripted memory responder with configurable
// ready/rvalid delays, checked against hand-computed results.
module tb_lsu_mem_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, done, err;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.AW(8), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .done       (done),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Results of the last access
  logic [31:0] r_rdata, r_wdata;
  logic [7:0]  r_addr;
  logic [3:0]  r_strb;
  logic        r_err, r_we, r_req_seen, r_seen_done, r_stall_done, r_done_after;
  int          r_cycles, r_unstable, r_stall_bad;

  // Starts at posedge+1 in IDLE and returns at posedge+1 back in IDLE.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int rdy_dly, input int rv_dly,
                        input logic [31:0] rword);
    int req_cnt, rv_cnt;
    bit ready_given, first;
    req_cnt = 0; rv_cnt = 0; ready_given = 0; first = 1;
    r_cycles = 0; r_req_seen = 0; r_unstable = 0; r_stall_bad = 0; r_seen_done = 0;
    r_rdata = 32'hDEAD_BEEF; r_err = 1'bx; r_stall_done = 1'bx;
    r_addr = 8'h00; r_strb = 4'h0; r_wdata = 32'h0; r_we = 1'b0;
    req = 1'b1; we = st; funct3 = f3; addr = a; wdata = wd;
    while (!r_seen_done && r_cycles < 60) begin
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      if (mem_req) begin
        r_req_seen = 1'b1;
        if (first) begin
          r_addr = mem_addr; r_strb = mem_wstrb; r_wdata = mem_wdata; r_we = mem_we;
          first = 0;
        end else if ({r_addr, r_strb, r_wdata, r_we} !== {mem_addr, mem_wstrb, mem_wdata, mem_we})
          r_unstable++;
        if (req_cnt == rdy_dly) begin
          mem_ready = 1'b1; ready_given = 1;
          if (!st && rv_dly == 0) begin mem_rvalid = 1'b1; mem_rdata = rword; end
        end
        req_cnt++;
      end else if (ready_given && !st) begin
        rv_cnt++;
        if (rv_cnt == rv_dly) begin mem_rvalid = 1'b1; mem_rdata = rword; end
      end
      @(negedge clk);
      if (stall !== 1'b1) r_stall_bad++;
      @(posedge clk); #1;
      r_cycles++;
      if (done) begin
        r_seen_done = 1'b1; r_rdata = rdata; r_err = err; r_stall_done = stall;
      end
    end
    req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    r_done_after = done;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_ctl", {28'h0, done, err, stall, mem_req}, 32'h0);
    check("rst_mem", {23'h0, mem_we, mem_addr}, 32'h0);
    check("rst_strb", {28'h0, mem_wstrb}, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Zero-wait lw
    access(1'b0, LW, 32'h64, 32'h0, 0, 0, 32'h0000_0019);
    check("lw_cycles", r_cycles, 2);
    check("lw_rdata", r_rdata, 32'h19);
    check("lw_err", r_err, 1'b0);
    check("lw_addr", r_addr, 8'h19);
    check("lw_stall_done", r_stall_done, 1'b0);
    check("lw_pulse", r_done_after, 1'b0);

    access(1'b1, SB, 32'h61, 32'hAABB_CCDD, 0, 0, 32'h0);
    check("sb_strb", r_strb, 4'b0010);
    check("sb_wdata", r_wdata, 32'hDDDD_DDDD);
    check("sb_we", r_we, 1'b1);
    check("sb_addr", r_addr, 8'h18);
    check("sb_err", {r_seen_done, r_err}, 2'b10);

    access(1'b1, SH, 32'h62, 32'h1234_BEEF, 0, 0, 32'h0);
    check("sh_strb", r_strb, 4'b1100);
    check("sh_wdata", r_wdata, 32'hBEEF_BEEF);

    access(1'b0, LB, 32'h63, 32'h0, 0, 0, 32'h80FF_1234);
    check("lb_rdata", r_rdata, 32'hFFFF_FF80);
    access(1'b0, LBU, 32'h63, 32'h0, 0, 0, 32'h80FF_1234);
    check("lbu_rdata", r_rdata, 32'h0000_0080);
    access(1'b0, LH, 32'h62, 32'h0, 0, 0, 32'h80FF_1234);
    check("lh_rdata", r_rdata, 32'hFFFF_80FF);

    // Slow memory: ready after 3 cycles, rvalid 2 cycles later
    access(1'b0, LW, 32'h68, 32'h0, 3, 2, 32'hCAFE_F00D);
    check("slow_cycles", r_cycles, 7);
    check("slow_stall", r_stall_bad, 0);
    check("slow_stable", r_unstable, 0);
    check("slow_rdata", r_rdata, 32'hCAFE_F00D);
    check("slow_err", r_err, 1'b0);
    check("slow_pulse", r_done_after, 1'b0);

    access(1'b0, LW, 32'h66, 32'h0, 0, 0, 32'h1111_1111);
    check("mis_cycles", r_cycles, 1);
    check("mis_err", r_err, 1'b1);
    check("mis_noreq", r_req_seen, 1'b0);
    check("mis_rdata", r_rdata, 32'h0);

    access(1'b1, 3'b011, 32'h64, 32'h5555_5555, 0, 0, 32'h0);
    check("ill_cycles", r_cycles, 1);
    check("ill_err", r_err, 1'b1);
    check("ill_noreq", r_req_seen, 1'b0);

    access(1'b0, LHU, 32'h62, 32'h0, 0, 0, 32'h80FF_1234);
    check("lhu_rdata", r_rdata, 32'h0000_80FF);

    // Memory never answers
    access(1'b0, LW, 32'h6C, 32'h0, 1000, 0, 32'h0);
    check("tmo_cycles", r_cycles, 17);
    check("tmo_err", r_err, 1'b1);
    check("tmo_rdata", r_rdata, 32'h0);
    check("tmo_req", r_req_seen, 1'b1);
    check("tmo_stall", r_stall_bad, 0);

    // Reset while a request is pending in ISSUE
    req = 1'b1; we = 1'b0; funct3 = LW; addr = 32'h70;
    @(posedge clk); #1;
    check("iss_req", mem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("iss_rst", {stall, mem_req}, 2'b00);
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset while in WAIT
    req = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("wait_stall", {stall, mem_req}, 2'b10);
    #2 reset = 1'b1;
    #1;
    check("wait_rst", {stall, mem_req, done}, 3'b000);
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    access(1'b0, LBU, 32'h71, 32'h0, 0, 1, 32'h0000_AB00);
    check("post_rdata", r_rdata, 32'h0000_00AB);
    check("post_err", {r_seen_done, r_err}, 2'b10);
    check("post_cycles", r_cycles, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
